block_pe_param: RTL and testbench

//  Parametrised dataflow PE for the CGRA fabric; successor to the fixed 2-in/1-out ALU+MEM PE.
//  - NUM_IN input channels, NUM_OUT output channels, each with a valid bit; ALU and MEM results feed back internally.
//  - Adds token firing, a registered pipeline and an on-clock config scan chain.
//  - Tiled by the array generator in the same way as the existing PE blocks.

---
 rtl/block_pe_pkg.sv | 55 +++++
 rtl/block_pe_param_alu.sv | 62 ++++++
 rtl/block_pe_param.sv | 158 +++++++++++++++
 tb/tb_block_pe_param.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_pe_pkg.sv
// Shared definitions for the parametrised CGRA PE: ALU/MEM codes, FSM states
// and config-chain field layout as functions of the channel counts.
package block_pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_RUN  = 2'd2
  } pe_state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_SHR  = 4'd7;
  localparam logic [3:0] ALU_ASHR = 4'd8;
  localparam logic [3:0] ALU_LT   = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;
  localparam logic [3:0] ALU_MAC  = 4'd12;

  localparam logic [1:0] MEM_OFF   = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  // Source selector width: inputs plus the ALU and MEM feedback registers.
  function automatic int sel_w(input int num_in);
    return $clog2(num_in + 2);
  endfunction

  // Config layout, LSB first: sel_a, sel_b, sel_c, sel_d, alu_op, mem_mode, out_sel.
  function automatic int off_sel(input int num_in, input int idx);
    return idx * sel_w(num_in);
  endfunction

  function automatic int off_op(input int num_in);
    return 4 * sel_w(num_in);
  endfunction

  function automatic int off_mem(input int num_in);
    return off_op(num_in) + 4;
  endfunction

  function automatic int off_out(input int num_in);
    return off_mem(num_in) + 2;
  endfunction

  function automatic int cfg_w(input int num_in, input int num_out);
    return off_out(num_in) + num_out;
  endfunction

endpackage

// File: rtl/block_pe_param_alu.sv
// pe_alu: combinational op decode. With BLOCK_PE_PARAM_MAC_EN defined it also
// owns the MAC accumulator (op 12); otherwise op 12 falls into the default.
module pe_alu import block_pe_pkg::*; #(
  parameter int WIDTH = 32
) (
`ifdef BLOCK_PE_PARAM_MAC_EN
  input  logic             clk,
  input  logic             reset,
  input  logic             fire,
  input  logic             clr,
`endif
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);
  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

`ifdef BLOCK_PE_PARAM_MAC_EN
  logic [WIDTH-1:0] acc_q, acc_d, mac_sum;
  assign mac_sum = acc_q + a * b;

  // Accumulator next value: cleared while configuring, advanced on a MAC fire.
  always_comb begin
    acc_d = acc_q;
    if (clr)                         acc_d = '0;
    else if (fire && op == ALU_MAC)  acc_d = mac_sum;
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end
`endif

  // Op decode; unknown codes give 0 but the caller still marks the result valid.
  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_MUL:  res = a * b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SHL:  res = a << shamt;
      ALU_SHR:  res = a >> shamt;
      ALU_ASHR: res = $signed(a) >>> shamt;
      ALU_LT:   res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_EQ:   res = {{(WIDTH-1){1'b0}}, a == b};
      ALU_PASS: res = a;
`ifdef BLOCK_PE_PARAM_MAC_EN
      ALU_MAC:  res = mac_sum;
`endif
      default:  res = '0;
    endcase
  end
endmodule

// File: rtl/block_pe_param.sv
// block_pe_param: parametrised dataflow PE with token firing, ALU/MEM result
// feedback, 2-cycle registered pipeline and a serial config chain.
// Optional MAC op enabled by defining BLOCK_PE_PARAM_MAC_EN.
module block_pe_param import block_pe_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 2,
  parameter int MEM_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     config_en,
  input  logic                     config_in,
  output logic                     config_out,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid
);
  localparam int SELW    = sel_w(NUM_IN);
  localparam int AW      = $clog2(MEM_DEPTH);
  localparam int OFF_OP  = off_op(NUM_IN);
  localparam int OFF_MEM = off_mem(NUM_IN);
  localparam int OFF_OUT = off_out(NUM_IN);
  localparam int CFG_W   = cfg_w(NUM_IN, NUM_OUT);
  localparam int NSRC    = NUM_IN + 2;

  pe_state_e                      state_q, state_d;
  logic [CFG_W-1:0]               cfg_q, cfg_d;
  logic                           config_out_q, config_out_d;
  logic [WIDTH-1:0]               alu_res_q, alu_res_d, mem_res_q, mem_res_d, alu_f;
  logic                           alu_vld_q, alu_vld_d, mem_vld_q, mem_vld_d;
  logic [NUM_OUT-1:0][WIDTH-1:0]  out_data_q, out_data_d;
  logic [NUM_OUT-1:0]             out_valid_q, out_valid_d;
  logic [WIDTH-1:0]               mem_q [MEM_DEPTH];

  logic [NSRC-1:0][WIDTH-1:0]     src_data;
  logic [NSRC-1:0]                src_vld;
  logic [3:0][SELW-1:0]           sel;
  logic [3:0][WIDTH-1:0]          opnd;
  logic [3:0]                     opnd_vld;
  logic [3:0]                     alu_op;
  logic [1:0]                     mem_mode;
  logic [NUM_OUT-1:0]             out_sel;
  logic                           run, alu_fire, ld_fire, st_fire;
  logic [AW-1:0]                  addr;
  logic                           unused_addr_hi;

  // Source table: input channels first, then ALU and MEM feedback.
  for (genvar k = 0; k < NUM_IN; k++) begin : g_src
    assign src_data[k] = in_data[k*WIDTH +: WIDTH];
    assign src_vld[k]  = in_valid[k];
  end
  assign src_data[NUM_IN]   = alu_res_q;
  assign src_vld[NUM_IN]    = alu_vld_q;
  assign src_data[NUM_IN+1] = mem_res_q;
  assign src_vld[NUM_IN+1]  = mem_vld_q;

  assign alu_op   = cfg_q[OFF_OP +: 4];
  assign mem_mode = cfg_q[OFF_MEM +: 2];
  assign out_sel  = cfg_q[OFF_OUT +: NUM_OUT];

  // Operand muxes; selectors beyond the table read as zero and never valid.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sel[i]      = cfg_q[off_sel(NUM_IN, i) +: SELW];
      opnd[i]     = '0;
      opnd_vld[i] = 1'b0;
      if (int'(sel[i]) < NSRC) begin
        opnd[i]     = src_data[sel[i]];
        opnd_vld[i] = src_vld[sel[i]];
      end
    end
  end

  assign run            = (state_q == ST_RUN);
  assign addr           = opnd[2][AW-1:0];
  assign unused_addr_hi = ^opnd[2][WIDTH-1:AW];
  assign alu_fire       = run & opnd_vld[0] & opnd_vld[1];
  assign ld_fire        = run & (mem_mode == MEM_LOAD) & opnd_vld[2];
  assign st_fire        = run & (mem_mode == MEM_STORE) & opnd_vld[2] & opnd_vld[3];

  pe_alu #(.WIDTH(WIDTH)) u_alu (
`ifdef BLOCK_PE_PARAM_MAC_EN
    .clk   (clk),
    .reset (reset),
    .fire  (alu_fire),
    .clr   (state_q == ST_CFG),
`endif
    .op    (alu_op),
    .a     (opnd[0]),
    .b     (opnd[1]),
    .res   (alu_f)
  );

  // FSM next state: config_en always wins; leaving CFG goes straight to RUN.
  always_comb begin
    state_d = state_q;
    if (config_en)               state_d = ST_CFG;
    else if (state_q == ST_CFG)  state_d = ST_RUN;
  end

  // Scan chain: shift toward bit 0, the bit falling off becomes config_out.
  always_comb begin
    cfg_d        = cfg_q;
    config_out_d = config_out_q;
    if (config_en) begin
      cfg_d        = {config_in, cfg_q[CFG_W-1:1]};
      config_out_d = cfg_q[0];
    end
  end

  // Result and output stage; valids only propagate while running.
  always_comb begin
    alu_res_d = alu_fire ? alu_f : alu_res_q;
    alu_vld_d = alu_fire;
    mem_res_d = ld_fire ? mem_q[addr] : mem_res_q;
    mem_vld_d = ld_fire;
    for (int k = 0; k < NUM_OUT; k++) begin
      out_data_d[k]  = out_sel[k] ? mem_res_q : alu_res_q;
      out_valid_d[k] = run & (out_sel[k] ? mem_vld_q : alu_vld_q);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      config_out_q <= 1'b0;
      alu_res_q    <= '0;
      alu_vld_q    <= 1'b0;
      mem_res_q    <= '0;
      mem_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      config_out_q <= config_out_d;
      alu_res_q    <= alu_res_d;
      alu_vld_q    <= alu_vld_d;
      mem_res_q    <= mem_res_d;
      mem_vld_q    <= mem_vld_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Scratchpad write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (st_fire) mem_q[addr] <= opnd[3];
  end

  assign config_out = config_out_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
endmodule

// File: tb/tb_block_pe_param.sv
// Bench for block_pe_param at default parameters: directed token tests plus
// randomized configs checked every cycle against a behavioural model.
module tb_block_pe_param;
  logic         clk = 1'b0;
  logic         reset;
  logic         config_en, config_in, config_out;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [63:0]  out_data;
  logic [1:0]   out_valid;

  int nvec = 0;
  int nerr = 0;

  block_pe_param #(.WIDTH(32), .NUM_IN(4), .NUM_OUT(2), .MEM_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .config_en(config_en), .config_in(config_in),
    .config_out(config_out), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Config word (20 bits): sel a/b/c/d at 0,3,6,9; op 12; mem mode 16; out_sel 18.
  logic [19:0]      m_cfg;
  logic             m_cfgo;
  int               m_st;      // 0 idle, 1 configuring, 2 running
  logic [31:0]      m_ar, m_mr, m_acc;
  logic             m_av, m_mv;
  logic [1:0]       m_ov;
  logic [1:0][31:0] m_od;
  logic [31:0]      m_mem [16];

  function automatic logic [31:0] src_val(input logic [2:0] s);
    if (s < 3'd4)  return in_data[s*32 +: 32];
    if (s == 3'd4) return m_ar;
    if (s == 3'd5) return m_mr;
    return 32'd0;
  endfunction

  function automatic logic src_ok(input logic [2:0] s);
    if (s < 3'd4)  return in_valid[s];
    if (s == 3'd4) return m_av;
    if (s == 3'd5) return m_mv;
    return 1'b0;
  endfunction

  function automatic logic [3:0] src_addr(input logic [2:0] s);
    logic [31:0] v;
    v = src_val(s);
    return v[3:0];
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] acc);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * b;
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return a ^ b;
      4'd6:  return a << sh;
      4'd7:  return a >> sh;
      4'd8:  return $signed(a) >>> sh;
      4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: return (a == b) ? 32'd1 : 32'd0;
      4'd11: return a;
`ifdef BLOCK_PE_PARAM_MAC_EN
      4'd12: return acc + a * b;
`endif
      default: return 32'd0 & acc;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cfg <= '0; m_cfgo <= 1'b0; m_st <= 0;
      m_ar <= '0; m_mr <= '0; m_av <= 1'b0; m_mv <= 1'b0; m_acc <= '0;
      m_ov <= '0; m_od <= '0;
    end else begin
      if (m_st == 2 && src_ok(m_cfg[2:0]) && src_ok(m_cfg[5:3])) begin
        m_ar <= ref_alu(m_cfg[15:12], src_val(m_cfg[2:0]), src_val(m_cfg[5:3]), m_acc);
        m_av <= 1'b1;
        if (m_cfg[15:12] == 4'd12)
          m_acc <= m_acc + src_val(m_cfg[2:0]) * src_val(m_cfg[5:3]);
      end else begin
        m_av <= 1'b0;
      end
      if (m_st == 1) m_acc <= '0;
      if (m_st == 2 && m_cfg[17:16] == 2'd1 && src_ok(m_cfg[8:6])) begin
        m_mr <= m_mem[src_addr(m_cfg[8:6])];
        m_mv <= 1'b1;
      end else begin
        m_mv <= 1'b0;
      end
      if (m_st == 2 && m_cfg[17:16] == 2'd2 && src_ok(m_cfg[8:6]) && src_ok(m_cfg[11:9]))
        m_mem[src_addr(m_cfg[8:6])] <= src_val(m_cfg[11:9]);
      for (int k = 0; k < 2; k++) begin
        m_ov[k] <= (m_st == 2) && (m_cfg[18+k] ? m_mv : m_av);
        m_od[k] <= m_cfg[18+k] ? m_mr : m_ar;
      end
      if (config_en) begin
        m_cfg  <= {config_in, m_cfg[19:1]};
        m_cfgo <= m_cfg[0];
      end
      if (config_en)      m_st <= 1;
      else if (m_st == 1) m_st <= 2;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  task automatic compare();
    nvec++;
    if (out_valid !== m_ov) begin
      nerr++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_ov, $time);
    end
    nvec++;
    if (config_out !== m_cfgo) begin
      nerr++;
      $display("FAIL config_out: got %b expected %b at %0t", config_out, m_cfgo, $time);
    end
    for (int k = 0; k < 2; k++) begin
      if (m_ov[k]) begin
        nvec++;
        if (out_data[k*32 +: 32] !== m_od[k]) begin
          nerr++;
          $display("FAIL out_data[%0d]: got %h expected %h at %0t", k, out_data[k*32 +: 32], m_od[k], $time);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  function automatic logic [19:0] mk_cfg(input int sa, sb, sc, sd, op, mm, os);
    logic [19:0] c;
    c = {os[1:0], mm[1:0], op[3:0], sd[2:0], sc[2:0], sb[2:0], sa[2:0]};
    return c;
  endfunction

  // Shift a config in bit 0 first, then one idle cycle to enter RUN.
  task automatic load_cfg(input logic [19:0] c);
    in_valid = '0;
    for (int i = 0; i < 20; i++) begin
      config_en = 1'b1; config_in = c[i];
      tick();
    end
    config_en = 1'b0; config_in = 1'b0;
    tick();
  endtask

  // One token cycle on the listed channels, then one more cycle so the
  // result reaches the outputs (2-cycle latency) before the caller checks.
  task automatic run2(input logic [31:0] d0, d1, input logic [3:0] v);
    in_data  = {32'd0, 32'd0, d1, d0};
    in_valid = v;
    tick();
    in_valid = '0;
    tick();
  endtask

  initial begin
    reset = 1'b0; config_en = 1'b0; config_in = 1'b0; in_data = '0; in_valid = '0;
    tick(); tick();
    chk("rst_out_valid", {30'd0, out_valid}, 32'd0);
    chk("rst_out_data0", out_data[31:0], 32'd0);
    chk("rst_config_out", {31'd0, config_out}, 32'd0);
    reset = 1'b1;
    tick();

    // ADD 5+7 on out0, exactly two cycles, single cycle
    load_cfg(mk_cfg(0, 1, 0, 0, 0, 0, 0));
    run2(32'd5, 32'd7, 4'b0011);
    chk("add_valid", {31'd0, out_valid[0]}, 32'd1);
    chk("add_data", out_data[31:0], 32'd12);
    chk("add_model", m_od[0], 32'd12);
    tick();
    chk("add_single", {31'd0, out_valid[0]}, 32'd0);

    // only in0 valid -> no firing
    in_data = {96'd0, 32'd3}; in_valid = 4'b0001;
    tick(); tick(); tick();
    in_valid = '0;
    tick(); tick();
    chk("half_valid", {30'd0, out_valid}, 32'd0);

    load_cfg(mk_cfg(0, 1, 0, 0, 1, 0, 0));
    run2(32'd3, 32'd5, 4'b0011);
    chk("sub_data", out_data[31:0], 32'hFFFF_FFFE);
    chk("sub_model", m_od[0], 32'hFFFF_FFFE);

    load_cfg(mk_cfg(0, 1, 0, 0, 9, 0, 0));
    run2(32'hFFFF_FFFF, 32'd0, 4'b0011);
    chk("lt_data", out_data[31:0], 32'd1);

    // STORE addr 17 (wraps to 1) data 9; LOAD addr 1 onto out0
    load_cfg(mk_cfg(0, 1, 0, 1, 0, 2, 0));
    run2(32'd17, 32'd9, 4'b0011);
    load_cfg(mk_cfg(0, 1, 0, 0, 0, 1, 1));
    run2(32'd1, 32'd0, 4'b0001);
    chk("load_valid", {31'd0, out_valid[0]}, 32'd1);
    chk("load_data", out_data[31:0], 32'd9);
    chk("load_model", m_od[0], 32'd9);

    // Feedback: MEM result (mem[1]=9) feeds ALU operand a, plus in1=100
    load_cfg(mk_cfg(5, 1, 0, 0, 0, 1, 0));
    in_data = {64'd0, 32'd100, 32'd1}; in_valid = 4'b0001; tick();
    in_valid = 4'b0010; tick();
    in_valid = 4'b0000; tick();
    chk("fb_valid", {31'd0, out_valid[0]}, 32'd1);
    chk("fb_data", out_data[31:0], 32'd109);

    // op 12: MAC when enabled, undefined op otherwise
    load_cfg(mk_cfg(0, 1, 0, 0, 12, 0, 0));
    run2(32'd2, 32'd3, 4'b0011);
    chk("op12_valid", {31'd0, out_valid[0]}, 32'd1);
`ifdef BLOCK_PE_PARAM_MAC_EN
    chk("mac_first", out_data[31:0], 32'd6);
    run2(32'd4, 32'd5, 4'b0011);
    chk("mac_second", out_data[31:0], 32'd26);
    load_cfg(mk_cfg(0, 1, 0, 0, 12, 0, 0));
    run2(32'd1, 32'd1, 4'b0011);
    chk("mac_cleared", out_data[31:0], 32'd1);
`else
    chk("op12_zero", out_data[31:0], 32'd0);
`endif

    // Fill scratchpad with known data so random loads are defined
    load_cfg(mk_cfg(0, 1, 0, 1, 0, 2, 0));
    for (int a = 0; a < 16; a++) begin
      in_data  = {64'd0, $urandom, 32'(a)};
      in_valid = 4'b0011;
      tick();
    end
    in_valid = '0;
    tick();

    // Randomized configs and tokens, checked every cycle by compare()
    for (int r = 0; r < 12; r++) begin
      load_cfg(20'($urandom));
      for (int c = 0; c < 30; c++) begin
        for (int k = 0; k < 4; k++)
          in_data[k*32 +: 32] = ($urandom % 2 != 0) ? $urandom : $urandom_range(0, 40);
        in_valid = 4'($urandom);
        tick();
      end
    end

    // Reset mid-stream with all inputs valid: outputs clear immediately
    load_cfg(mk_cfg(0, 1, 0, 0, 0, 0, 3'b11));
    in_data = {32'd4, 32'd3, 32'd2, 32'd1}; in_valid = 4'hF;
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_valid", {30'd0, out_valid}, 32'd0);
    chk("midrst_out_data", out_data[31:0] | out_data[63:32], 32'd0);
    chk("midrst_config_out", {31'd0, config_out}, 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("post_rst_idle", {30'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
